// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable wait latency
module dmem_responder #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] mem_d [2**ADDR_W];
  logic idle, enter_resp, cur_wr, cur_err;
  logic [15:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] cur_idx;
  // In IDLE the live request is used so a zero-latency build can respond on the accept edge.
  assign idle      = state_q == S_IDLE;
  assign cur_wr    = idle ? req_write : wr_q;
  assign cur_addr  = idle ? req_addr : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign cur_idx   = cur_addr[ADDR_W:1];
  assign cur_err   = cur_addr[0] | (|cur_addr[15:ADDR_W+1]);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_d      = mem_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (LATENCY == 0) enter_resp = 1'b1;
        else begin
          state_d = S_WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: if (cnt_q == 4'd0) enter_resp = 1'b1;
              else cnt_d = cnt_q - 4'd1;
      default: if (rsp_ready) state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      state_d = S_RESP;
      err_d   = cur_err;
      rdata_d = (cur_wr | cur_err) ? '0 : mem_q[cur_idx];
      if (cur_wr && !cur_err) mem_d[cur_idx] = cur_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign busy      = state_q != S_IDLE;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for LATENCY=2 (unit 0) and LATENCY=0 (unit 1) builds
module tb_dmem_responder;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0][15:0] req_addr, req_wdata, rsp_rdata;
  typedef struct {logic [15:0] rd; logic err;} exp_t;
  exp_t sb[$];
  logic [15:0] mdl [2][8];
  int n_cmp = 0, n_bad = 0;
  dmem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));
  dmem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int u = 0; u < 2; u++) for (int i = 0; i < 8; i++) mdl[u][i] = 16'h0;
  endtask
  task automatic check_idle(input int u, input string tag);
    check($sformatf("%s u%0d rsp_valid", tag, u), rsp_valid[u], 0);
    check($sformatf("%s u%0d req_ready", tag, u), req_ready[u], 1);
    check($sformatf("%s u%0d busy", tag, u), busy[u], 0);
  endtask
  task automatic xact(input int u, input logic w, input logic [15:0] a, input logic [15:0] d, input int hold);
    exp_t e;
    int n;
    logic [15:0] rd0;
    logic er0;
    e.err = a[0] | (|a[15:4]);
    e.rd  = (w | e.err) ? 16'h0 : mdl[u][a[3:1]];
    if (w && !e.err) mdl[u][a[3:1]] = d;
    sb.push_back(e);
    check($sformatf("u%0d req_ready before accept", u), req_ready[u], 1);
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a; req_wdata[u] = d;
    @(posedge clk); #1;
    req_valid[u] = 1'b0; req_write[u] = ~w; req_addr[u] = 16'hFFFF; req_wdata[u] = 16'h5A5A;
    n = 0;
    while (!rsp_valid[u] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("u%0d latency a=%0h", u, a), n, u ? 0 : 2);
    rd0 = rsp_rdata[u];
    er0 = rsp_err[u];
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold rsp_valid", rsp_valid[u], 1);
      check("hold rdata", rsp_rdata[u], rd0);
      check("hold err", rsp_err[u], er0);
      check("hold req_ready", req_ready[u], 0);
      check("hold busy", busy[u], 1);
    end
    e = sb.pop_front();
    check($sformatf("u%0d w=%0d a=%0h rdata", u, w, a), rsp_rdata[u], e.rd);
    check($sformatf("u%0d w=%0d a=%0h err", u, w, a), rsp_err[u], e.err);
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
    check_idle(u, "post-handshake");
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_idle(u, "reset");
      check($sformatf("reset u%0d rdata", u), rsp_rdata[u], 0);
      check($sformatf("reset u%0d err", u), rsp_err[u], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    xact(0, 1, 16'h0004, 16'h1234, 0);
    xact(0, 0, 16'h0004, 16'h0000, 0);
    xact(0, 1, 16'h0005, 16'hBEEF, 0);
    xact(0, 0, 16'h0004, 16'h0000, 0);
    xact(0, 0, 16'h0010, 16'h0000, 0);
    xact(0, 0, 16'h0004, 16'h0000, 5);
    // reset while a store sits in WAIT: nothing answers and memory comes back cleared
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0002; req_wdata[0] = 16'hAAAA;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("mid-reset busy before", busy[0], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    check_idle(0, "mid-reset");
    check("mid-reset rdata", rsp_rdata[0], 0);
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        seen |= rsp_valid[0];
      end
      check("mid-reset no response", seen, 0);
    end
    xact(0, 0, 16'h0002, 16'h0000, 0);
    xact(0, 0, 16'h0004, 16'h0000, 0);
    xact(1, 1, 16'h000E, 16'hCAFE, 0);
    xact(1, 0, 16'h000E, 16'h0000, 2);
    xact(1, 1, 16'h000F, 16'h1111, 0);
    xact(1, 0, 16'h0020, 16'h0000, 0);
    for (int k = 0; k < 40; k++) begin
      int u;
      logic [15:0] a;
      u = $urandom_range(0, 1);
      a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      xact(u, 1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 2));
    end
    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
